// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_pkg : shared constants, FSM state type and high-phase helper
// Revision    : 1.0
// ============================================================================
package clk_div_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // M/2 for even M and (M-1)/2 for odd M are both a right shift.
    function automatic logic [31:0] half_len(input logic [31:0] m);
        return m >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// clk_div_core : period counter, q1/q2 output flops, tick and odd/even select
// Revision     : 1.0
// ============================================================================
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] i_cur_div,
    input  logic             i_running_nxt,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_clk_out
);

    logic [DIV_W-1:0] r_count;
    logic             r_run;
    logic             r_q1;
    logic             r_q2;
    logic             r_tick;
    logic [DIV_W-1:0] w_count_nxt;
    logic [DIV_W-1:0] w_half;
    logic             w_wrap;

    assign w_half = DIV_W'(half_len(32'(i_cur_div)));
    assign w_wrap = r_run && (r_count == i_cur_div - DIV_W'(1));

    // A fresh start or a wrap both begin the period at count 0.
    always_comb begin
        w_count_nxt = '0;
        if (i_running_nxt && r_run && !w_wrap) begin
            w_count_nxt = r_count + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_run   <= 1'b0;
            r_q1    <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_run   <= i_running_nxt;
            r_q1    <= i_running_nxt && (w_count_nxt < w_half);
            r_tick  <= i_running_nxt && (w_count_nxt == '0);
        end
    end

    // Half-cycle extension of the high phase for odd divisors.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q2 <= 1'b0;
        end else begin
            r_q2 <= r_q1;
        end
    end

    assign o_wrap    = w_wrap;
    assign o_tick    = r_tick;
    assign o_clk_out = i_cur_div[0] ? (r_q1 | r_q2) : r_q1;

endmodule
`default_nettype wire

// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// prog_clk_div : runtime-programmable integer clock divider (f(clk)/M)
// Revision     : 1.0
// ============================================================================
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_RST  = 4,
    parameter int START_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             running,
    output logic             tick,
    output logic             clk_out
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_run_req;
    logic             w_running_nxt;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_bad;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_full;
    logic             r_err;

    assign w_run_req = en || (START_EN != 0);
    assign w_xfer    = div_valid && !r_pend_full;
    assign w_bad     = div_in < DIV_W'(MIN_DIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Losing the run request exactly on the wrap ends the period cleanly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_run_req) w_state_nxt = RUN;
            RUN:  if (!w_run_req) w_state_nxt = w_wrap ? IDLE : STOP;
            STOP: begin
                if (w_run_req)   w_state_nxt = RUN;
                else if (w_wrap) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running       = (r_state != IDLE);
        w_running_nxt = (w_state_nxt != IDLE);
    end

    // Divisors offered while running wait in r_pend until the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_div   <= DIV_W'(DIV_RST);
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_xfer && w_bad;
            if (w_xfer && !w_bad) begin
                if (r_state == IDLE) begin
                    r_cur_div <= div_in;
                end else begin
                    r_pend      <= div_in;
                    r_pend_full <= 1'b1;
                end
            end
            if (w_wrap && r_pend_full) begin
                r_cur_div   <= r_pend;
                r_pend_full <= 1'b0;
            end
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .i_cur_div     (r_cur_div),
        .i_running_nxt (w_running_nxt),
        .o_wrap        (w_wrap),
        .o_tick        (tick),
        .o_clk_out     (clk_out)
    );

    assign div_ready = !r_pend_full;
    assign div_err   = r_err;
    assign cur_div   = r_cur_div;

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
// tb_prog_clk_div : directed self-checking bench for prog_clk_div
// Revision        : 1.0
// ============================================================================
module tb_prog_clk_div;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;
    logic [DIV_W-1:0] cur_div;
    logic             running;
    logic             tick;
    logic             clk_out;

    int n_chk  = 0;
    int n_fail = 0;

    prog_clk_div #(
        .DIV_W    (DIV_W),
        .DIV_RST  (4),
        .START_EN (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_err   (div_err),
        .cur_div   (cur_div),
        .running   (running),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full period of divisor m, starting at the edge that begins count 0.
    // Optionally offers divisor val during count ok and drops en during count drop_k.
    task automatic period(input string tag, input int m, input int ok,
                          input int val, input int drop_k);
        int h;
        bit odd;
        bit offered;
        h       = m / 2;
        odd     = (m % 2) == 1;
        offered = 1'b0;
        for (int k = 0; k < m; k++) begin
            @(posedge clk); #1;
            if (offered && k == ok + 1) div_valid = 1'b0;
            chk({tag, " clk_out@pos"}, int'(clk_out), (k < h || (odd && k == h)) ? 1 : 0);
            chk({tag, " tick"},        int'(tick),    (k == 0) ? 1 : 0);
            chk({tag, " cur_div"},     int'(cur_div), m);
            chk({tag, " running"},     int'(running), 1);
            chk({tag, " ready"},       int'(div_ready), (offered && val >= 2 && k > ok) ? 0 : 1);
            chk({tag, " err"},         int'(div_err), (offered && val < 2 && k == ok + 1) ? 1 : 0);
            @(negedge clk); #1;
            chk({tag, " clk_out@neg"}, int'(clk_out), (k < h) ? 1 : 0);
            if (k == ok) begin
                div_in    = DIV_W'(val);
                div_valid = 1'b1;
                offered   = 1'b1;
            end
            if (k == drop_k) en = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst clk_out", int'(clk_out),   0);
        chk("rst tick",    int'(tick),      0);
        chk("rst running", int'(running),   0);
        chk("rst err",     int'(div_err),   0);
        chk("rst ready",   int'(div_ready), 1);
        chk("rst cur_div", int'(cur_div),   4);

        rst = 1'b0;
        en  = 1'b1;

        period("m4a", 4, -1, 0, -1);
        period("m4b", 4,  1, 5, -1);
        period("m5a", 5, -1, 0, -1);
        period("m5b", 5,  1, 1, -1);
        period("m5c", 5,  1, 0, -1);
        period("m5d", 5,  1, 2, -1);
        period("m2a", 2, -1, 0, -1);
        period("m2b", 2,  0, 3, -1);
        period("m3a", 3, -1, 0, -1);
        period("m3b", 3,  0, 6, -1);
        period("m6a", 6, -1, 0, -1);
        period("m6stop", 6, -1, 0, 1);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle clk_out", int'(clk_out), 0);
            chk("idle running", int'(running), 0);
            chk("idle tick",    int'(tick),    0);
            chk("idle cur_div", int'(cur_div), 6);
        end

        en = 1'b1;
        period("m6re", 6, 1, 5, -1);

        // Count 2 of M=5: clk_out is held high only by the negedge flop.
        @(posedge clk); #1;
        chk("m5r cur_div", int'(cur_div), 5);
        @(posedge clk);
        @(posedge clk); #1;
        chk("m5r clk_out high", int'(clk_out), 1);
        rst = 1'b1;
        #1;
        chk("arst clk_out", int'(clk_out),   0);
        chk("arst tick",    int'(tick),      0);
        chk("arst running", int'(running),   0);
        chk("arst err",     int'(div_err),   0);
        chk("arst ready",   int'(div_ready), 1);
        chk("arst cur_div", int'(cur_div),   4);

        @(negedge clk); #1;
        chk("arst clk_out@neg", int'(clk_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
